reg_demux4_stream: RTL and testbench

REG_DEMUX4_STREAM -- requirements
Module: reg_demux4_stream

---
 rtl/reg_demux4_stream_pkg.sv | 19 +
 rtl/reg_demux4_stream_if.sv | 32 +++
 rtl/reg_demux_slot.sv | 55 +++++
 rtl/reg_demux4_stream.sv | 64 ++++++
 tb/tb_reg_demux4_stream.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/reg_demux4_stream_pkg.sv
// Shared channel codes, counter width and the saturating-increment helper
// for the four-way registered stream demultiplexer.
package reg_demux4_stream_pkg;

  typedef enum logic [1:0] {
    CH_A = 2'd0,
    CH_B = 2'd1,
    CH_C = 2'd2,
    CH_D = 2'd3
  } chan_e;

  localparam int COUNT_WIDTH = 8;
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = 8'd255;

  function automatic logic [COUNT_WIDTH-1:0] satInc(input logic [COUNT_WIDTH-1:0] value);
    return (value == COUNT_MAX) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/reg_demux4_stream_if.sv
// Handshake and data bundle of the four-way demultiplexer: one upstream
// valid/ready port and four downstream valid/ready channels with counters.
interface reg_demux4_stream_if
  import reg_demux4_stream_pkg::*;
#(
  parameter int INPUT_BIT_WIDTH = 8,
  parameter int BUS_WIDTH       = 2
);

  logic [INPUT_BIT_WIDTH-1:0] Input;
  logic [BUS_WIDTH-1:0]       Select;
  logic                       InputValid;
  logic                       InputReady;

  logic [INPUT_BIT_WIDTH-1:0] OutputA, OutputB, OutputC, OutputD;
  logic                       ValidA, ValidB, ValidC, ValidD;
  logic                       ReadyA, ReadyB, ReadyC, ReadyD;
  logic [COUNT_WIDTH-1:0]     CountA, CountB, CountC, CountD;

  modport master (
    output Input, Select, InputValid, ReadyA, ReadyB, ReadyC, ReadyD,
    input  InputReady, OutputA, OutputB, OutputC, OutputD,
    input  ValidA, ValidB, ValidC, ValidD, CountA, CountB, CountC, CountD
  );

  modport slave (
    input  Input, Select, InputValid, ReadyA, ReadyB, ReadyC, ReadyD,
    output InputReady, OutputA, OutputB, OutputC, OutputD,
    output ValidA, ValidB, ValidC, ValidD, CountA, CountB, CountC, CountD
  );

endinterface

// File: rtl/reg_demux_slot.sv
// One channel slot: a single-word data register with a full flag and a
// saturating count of words handed downstream.
module reg_demux_slot
  import reg_demux4_stream_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                   Clk,
  input  logic                   ResetN,
  input  logic                   load,
  input  logic [WIDTH-1:0]       dataIn,
  input  logic                   ready,
  output logic [WIDTH-1:0]       dataOut,
  output logic                   valid,
  output logic [COUNT_WIDTH-1:0] count
);

  logic [WIDTH-1:0]       data_r;
  logic                   valid_r;
  logic [COUNT_WIDTH-1:0] count_r;
  logic                   deliver_s;

  assign deliver_s = valid_r && ready;

  // Load has priority over drain so a same-cycle deliver+accept stays full.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      data_r  <= '0;
      valid_r <= 1'b0;
      count_r <= '0;
    end else begin
      if (load) begin
        data_r  <= dataIn;
        valid_r <= 1'b1;
      end else if (deliver_s) begin
        data_r  <= data_r;
        valid_r <= 1'b0;
      end else begin
        data_r  <= data_r;
        valid_r <= valid_r;
      end

      if (deliver_s) begin
        count_r <= satInc(count_r);
      end else begin
        count_r <= count_r;
      end
    end
  end

  assign dataOut = data_r;
  assign valid   = valid_r;
  assign count   = count_r;

endmodule

// File: rtl/reg_demux4_stream.sv
// Four-way registered stream demultiplexer: routes each accepted word into
// the slot named by Select, with per-slot back-pressure.
module reg_demux4_stream
  import reg_demux4_stream_pkg::*;
#(
  parameter int INPUT_BIT_WIDTH = 8,
  parameter int BUS_WIDTH       = 2
) (
  input logic               Clk,
  input logic               ResetN,
  reg_demux4_stream_if.slave bus
);

  chan_e      sel_s;
  logic [3:0] validVec_s;
  logic [3:0] readyVec_s;
  logic [3:0] loadVec_s;
  logic       inputReady_s;

  assign sel_s      = chan_e'(bus.Select[1:0]);
  assign validVec_s = {bus.ValidD, bus.ValidC, bus.ValidB, bus.ValidA};
  assign readyVec_s = {bus.ReadyD, bus.ReadyC, bus.ReadyB, bus.ReadyA};

  // Ready looks only at the addressed slot; InputValid just gates the load.
  always_comb begin
    inputReady_s = 1'b0;
    loadVec_s    = 4'b0000;
    case (sel_s)
      CH_A:    inputReady_s = !validVec_s[0] || readyVec_s[0];
      CH_B:    inputReady_s = !validVec_s[1] || readyVec_s[1];
      CH_C:    inputReady_s = !validVec_s[2] || readyVec_s[2];
      CH_D:    inputReady_s = !validVec_s[3] || readyVec_s[3];
      default: inputReady_s = 1'b0;
    endcase
    if (bus.InputValid && inputReady_s) begin
      loadVec_s = 4'b0001 << sel_s;
    end else begin
      loadVec_s = 4'b0000;
    end
  end

  assign bus.InputReady = inputReady_s;

  reg_demux_slot #(.WIDTH(INPUT_BIT_WIDTH)) slotA (
    .Clk(Clk), .ResetN(ResetN), .load(loadVec_s[0]), .dataIn(bus.Input),
    .ready(bus.ReadyA), .dataOut(bus.OutputA), .valid(bus.ValidA), .count(bus.CountA)
  );

  reg_demux_slot #(.WIDTH(INPUT_BIT_WIDTH)) slotB (
    .Clk(Clk), .ResetN(ResetN), .load(loadVec_s[1]), .dataIn(bus.Input),
    .ready(bus.ReadyB), .dataOut(bus.OutputB), .valid(bus.ValidB), .count(bus.CountB)
  );

  reg_demux_slot #(.WIDTH(INPUT_BIT_WIDTH)) slotC (
    .Clk(Clk), .ResetN(ResetN), .load(loadVec_s[2]), .dataIn(bus.Input),
    .ready(bus.ReadyC), .dataOut(bus.OutputC), .valid(bus.ValidC), .count(bus.CountC)
  );

  reg_demux_slot #(.WIDTH(INPUT_BIT_WIDTH)) slotD (
    .Clk(Clk), .ResetN(ResetN), .load(loadVec_s[3]), .dataIn(bus.Input),
    .ready(bus.ReadyD), .dataOut(bus.OutputD), .valid(bus.ValidD), .count(bus.CountD)
  );

endmodule

// File: tb/tb_reg_demux4_stream.sv
// Directed, table-driven bench for reg_demux4_stream plus hand-written
// streaming, saturation and asynchronous-reset sequences.
module tb_reg_demux4_stream;

  logic Clk;
  logic ResetN;
  int   vecCnt;
  int   missCnt;

  reg_demux4_stream_if #(.INPUT_BIT_WIDTH(8), .BUS_WIDTH(2)) bus ();

  reg_demux4_stream #(.INPUT_BIT_WIDTH(8), .BUS_WIDTH(2)) dut (
    .Clk(Clk),
    .ResetN(ResetN),
    .bus(bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [1:0]  sel;
    logic [7:0]  din;
    logic        iv;
    logic [3:0]  rdy;       // {D,C,B,A}
    logic        expIr;     // InputReady before the edge
    logic [3:0]  expValid;  // {D,C,B,A} after the edge
    logic [31:0] expOut;    // {OutputD,C,B,A} after the edge
    logic [31:0] expCnt;    // {CountD,C,B,A} after the edge
  } vec_t;

  vec_t vecs[10];

  function automatic logic [31:0] getValid();
    return {28'd0, bus.ValidD, bus.ValidC, bus.ValidB, bus.ValidA};
  endfunction

  function automatic logic [31:0] getOut();
    return {bus.OutputD, bus.OutputC, bus.OutputB, bus.OutputA};
  endfunction

  function automatic logic [31:0] getCnt();
    return {bus.CountD, bus.CountC, bus.CountB, bus.CountA};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCnt++;
    if (act !== exp) begin
      missCnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] sel, input logic [7:0] din, input logic iv,
                       input logic [3:0] rdy);
    bus.Select     = sel;
    bus.Input      = din;
    bus.InputValid = iv;
    {bus.ReadyD, bus.ReadyC, bus.ReadyB, bus.ReadyA} = rdy;
  endtask

  task automatic doReset();
    @(negedge Clk);
    ResetN = 1'b0;
    drive(2'd0, 8'h00, 1'b0, 4'b0000);
    #1;
    chk("ready_in_reset", {31'd0, bus.InputReady}, 32'd1);
    @(posedge Clk);
    @(negedge Clk);
    ResetN = 1'b1;
    #1;
    chk("rst_valid", getValid(), 32'd0);
    chk("rst_out", getOut(), 32'd0);
    chk("rst_cnt", getCnt(), 32'd0);
    chk("rst_ready", {31'd0, bus.InputReady}, 32'd1);
  endtask

  initial begin
    vecCnt  = 0;
    missCnt = 0;
    ResetN  = 1'b0;
    drive(2'd0, 8'h00, 1'b0, 4'b0000);

    //            sel    din    iv    rdy      ir    valid    out           cnt
    vecs[0] = '{2'd2, 8'hA5, 1'b1, 4'b0000, 1'b1, 4'b0100, 32'h00A5_0000, 32'h0000_0000};
    vecs[1] = '{2'd2, 8'hFF, 1'b0, 4'b0000, 1'b0, 4'b0100, 32'h00A5_0000, 32'h0000_0000};
    vecs[2] = '{2'd0, 8'hFF, 1'b0, 4'b0000, 1'b1, 4'b0100, 32'h00A5_0000, 32'h0000_0000};
    vecs[3] = '{2'd1, 8'h11, 1'b1, 4'b0000, 1'b1, 4'b0110, 32'h00A5_1100, 32'h0000_0000};
    vecs[4] = '{2'd1, 8'h22, 1'b1, 4'b0000, 1'b0, 4'b0110, 32'h00A5_1100, 32'h0000_0000};
    vecs[5] = '{2'd1, 8'h22, 1'b1, 4'b0010, 1'b1, 4'b0110, 32'h00A5_2200, 32'h0000_0100};
    vecs[6] = '{2'd0, 8'h33, 1'b1, 4'b0110, 1'b1, 4'b0001, 32'h00A5_2233, 32'h0001_0200};
    vecs[7] = '{2'd3, 8'h44, 1'b1, 4'b1000, 1'b1, 4'b1001, 32'h44A5_2233, 32'h0001_0200};
    vecs[8] = '{2'd3, 8'h55, 1'b1, 4'b1001, 1'b1, 4'b1000, 32'h55A5_2233, 32'h0101_0201};
    vecs[9] = '{2'd0, 8'h66, 1'b0, 4'b1000, 1'b1, 4'b0000, 32'h55A5_2233, 32'h0201_0201};

    repeat (2) @(negedge Clk);
    ResetN = 1'b1;
    #1;
    chk("init_valid", getValid(), 32'd0);
    chk("init_out", getOut(), 32'd0);
    chk("init_cnt", getCnt(), 32'd0);
    chk("init_ready", {31'd0, bus.InputReady}, 32'd1);

    // Routing, back-pressure and simultaneous deliver/accept table.
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      drive(vecs[i].sel, vecs[i].din, vecs[i].iv, vecs[i].rdy);
      #1;
      chk($sformatf("vec%0d_ready", i), {31'd0, bus.InputReady}, {31'd0, vecs[i].expIr});
      @(posedge Clk);
      #1;
      chk($sformatf("vec%0d_valid", i), getValid(), {28'd0, vecs[i].expValid});
      chk($sformatf("vec%0d_out", i), getOut(), vecs[i].expOut);
      chk($sformatf("vec%0d_cnt", i), getCnt(), vecs[i].expCnt);
    end

    // Streaming: ten words into A at one per cycle with ReadyA held high.
    doReset();
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      drive(2'd0, 8'(i), 1'b1, 4'b0001);
      #1;
      chk("stream_ready", {31'd0, bus.InputReady}, 32'd1);
      @(posedge Clk);
      #1;
      chk("stream_valid", getValid(), 32'd1);
      chk("stream_data", {24'd0, bus.OutputA}, 32'(i));
      chk("stream_cnt", {24'd0, bus.CountA}, 32'(i));
    end
    @(negedge Clk);
    drive(2'd0, 8'h00, 1'b0, 4'b0001);
    @(posedge Clk);
    #1;
    chk("stream_drained", getValid(), 32'd0);
    chk("stream_final_cnt", getCnt(), 32'h0000_000A);

    // Saturation: 300 deliveries on D.
    doReset();
    for (int n = 0; n < 300; n++) begin
      @(negedge Clk);
      drive(2'd3, 8'(n), 1'b1, 4'b1000);
      @(posedge Clk);
      #1;
      chk("sat_cnt", {24'd0, bus.CountD}, (n > 255) ? 32'd255 : 32'(n));
    end
    for (int n = 0; n < 4; n++) begin
      @(negedge Clk);
      drive(2'd3, 8'h00, 1'b0, 4'b1000);
      @(posedge Clk);
      #1;
      chk("sat_hold", {24'd0, bus.CountD}, 32'd255);
      chk("sat_valid", getValid(), 32'd0);
    end

    // Asynchronous reset between edges with A and C holding words.
    doReset();
    @(negedge Clk);
    drive(2'd1, 8'h77, 1'b1, 4'b0000);
    @(negedge Clk);
    drive(2'd0, 8'h5A, 1'b1, 4'b0010);
    @(negedge Clk);
    drive(2'd2, 8'hC3, 1'b1, 4'b0000);
    @(posedge Clk);
    #1;
    chk("pre_rst_valid", getValid(), 32'b0101);
    chk("pre_rst_cnt", getCnt(), 32'h0000_0100);
    @(negedge Clk);
    drive(2'd0, 8'h99, 1'b0, 4'b0000);
    #2;
    ResetN = 1'b0;
    #1;
    chk("async_valid", getValid(), 32'd0);
    chk("async_out", getOut(), 32'd0);
    chk("async_cnt", getCnt(), 32'd0);
    chk("async_ready", {31'd0, bus.InputReady}, 32'd1);
    drive(2'd0, 8'h99, 1'b1, 4'b0000);
    @(posedge Clk);
    #1;
    chk("no_accept_in_reset", getValid(), 32'd0);
    chk("no_load_in_reset", getOut(), 32'd0);
    @(negedge Clk);
    drive(2'd0, 8'h00, 1'b0, 4'b0000);
    ResetN = 1'b1;
    @(posedge Clk);
    #1;
    chk("post_rst_valid", getValid(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt);
    $finish;
  end

endmodule
